// File: rtl/telemetry_pkg.sv
// Shared constants for the telemetry frame buffer: parameter defaults,
// channel index names and the sequence tag width.
package telemetry_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DEPTH    = 8;

  localparam int CH_X = 0;
  localparam int CH_Y = 1;
  localparam int CH_Z = 2;
  localparam int CH_T = 3;

  localparam int SEQ_W = 8;

endpackage

// File: rtl/telemetry_fifo.sv
// First-word-fall-through frame FIFO: the head entry is visible on dout
// whenever count is non-zero; a push while full is accepted only with a pop.
module telemetry_fifo #(
  parameter int DW    = 40,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_q[rptr_q];
  assign count     = count_q;

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push_s) wptr_d = wptr_q + PTR_ONE;
    else           wptr_d = wptr_q;
    if (do_pop_s)  rptr_d = rptr_q + PTR_ONE;
    else           rptr_d = rptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Frame storage, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/telemetry_buffer.sv
// Telemetry channel register bank with sequence-tagged frame snapshots
// pushed into a FWFT FIFO; sticky overflow flags dropped frames.
module telemetry_buffer
  import telemetry_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(CHANNELS)-1:0] wr_sel,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        commit,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHANNELS*WIDTH-1:0]   out_frame,
  output logic [7:0]                  out_seq,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  input  logic                        clr_ovf
);
  localparam int FW = CHANNELS * WIDTH;
  localparam int DW = FW + SEQ_W;

  logic [FW-1:0]    chan_q, chan_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d;
  logic             fifo_full_s, fifo_empty_s, pop_s, drop_s;
  logic [DW-1:0]    fifo_dout_s;

  assign pop_s  = out_ready && !fifo_empty_s;
  assign drop_s = commit && fifo_full_s && !pop_s;

  // chan_d doubles as the commit snapshot, so a same-cycle write is captured
  always_comb begin
    chan_d = chan_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (wr_en && (int'(wr_sel) == k)) chan_d[k*WIDTH +: WIDTH] = wr_data;
      else                              chan_d[k*WIDTH +: WIDTH] = chan_q[k*WIDTH +: WIDTH];
    end
  end

  // Sequence counter and overflow next state; a drop wins over clear
  always_comb begin
    seq_d = seq_q;
    ovf_d = ovf_q;
    if (commit) seq_d = seq_q + 8'd1;
    else        seq_d = seq_q;
    if (drop_s)       ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // Channel bank, sequence and overflow registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chan_q <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      chan_q <= chan_d;
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
    end
  end

  telemetry_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (commit),
    .pop   (out_ready),
    .din   ({seq_q, chan_d}),
    .dout  (fifo_dout_s),
    .count (count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign out_valid = !fifo_empty_s;
  assign out_frame = fifo_dout_s[FW-1:0];
  assign out_seq   = fifo_dout_s[DW-1 -: SEQ_W];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_telemetry_buffer.sv
// Scoreboard bench for telemetry_buffer: a reference model queues expected
// frames on commit and compares them against the head when popped.
module tb_telemetry_buffer;
  import telemetry_pkg::*;

  localparam int W = 8;
  localparam int C = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, commit = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [1:0]  wr_sel = 2'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        out_valid, overflow;
  logic [31:0] out_frame;
  logic [7:0]  out_seq;
  logic [3:0]  count;

  logic        wr_en5 = 1'b0, commit5 = 1'b0, out_ready5 = 1'b0, clr5 = 1'b0;
  logic [2:0]  wr_sel5 = 3'd0;
  logic [7:0]  wr_data5 = 8'd0;
  logic        out_valid5, overflow5;
  logic [39:0] out_frame5;
  logic [7:0]  out_seq5;
  logic [2:0]  count5;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [39:0] sb_q [$];
  logic [31:0] m_frame = 32'd0;
  logic [7:0]  m_seq = 8'd0;
  int          m_count = 0;
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  telemetry_buffer #(.WIDTH(W), .CHANNELS(C), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .commit(commit), .out_valid(out_valid), .out_ready(out_ready),
    .out_frame(out_frame), .out_seq(out_seq), .count(count),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  telemetry_buffer #(.WIDTH(8), .CHANNELS(5), .DEPTH(4)) u_dut5 (
    .clk(clk), .rst(rst), .wr_en(wr_en5), .wr_sel(wr_sel5), .wr_data(wr_data5),
    .commit(commit5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_frame(out_frame5), .out_seq(out_seq5), .count(count5),
    .overflow(overflow5), .clr_ovf(clr5)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: check pre-edge outputs, then advance the model
  task automatic step(input logic we, input int sel, input logic [7:0] d,
                      input logic cm, input logic rd, input logic cl);
    logic [39:0] exp_item;
    logic [31:0] f;
    logic        pop, drop;
    wr_en = we; wr_sel = sel[1:0]; wr_data = d; commit = cm; out_ready = rd; clr_ovf = cl;
    @(negedge clk);
    check_val("count", {60'd0, count}, m_count);
    check_val("valid", {63'd0, out_valid}, {63'd0, m_count != 0});
    check_val("ovf", {63'd0, overflow}, {63'd0, m_ovf});
    pop = rd && (m_count != 0);
    if (pop) begin
      exp_item = sb_q.pop_front();
      check_val("frame", {32'd0, out_frame}, {32'd0, exp_item[31:0]});
      check_val("seq", {56'd0, out_seq}, {56'd0, exp_item[39:32]});
    end
    f = m_frame;
    if (we && sel < C) f[sel*W +: W] = d;
    drop = cm && (m_count == D) && !pop;
    if (cm && !drop) sb_q.push_back({m_seq, f});
    m_count = m_count + ((cm && !drop) ? 1 : 0) - (pop ? 1 : 0);
    if (drop)    m_ovf = 1'b1;
    else if (cl) m_ovf = 1'b0;
    if (cm) m_seq = m_seq + 8'd1;
    m_frame = f;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    wr_en = 1'b0; commit = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_val("rst_count", {60'd0, count}, 64'd0);
    check_val("rst_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_ovf", {63'd0, overflow}, 64'd0);
    sb_q.delete();
    m_frame = 32'd0; m_seq = 8'd0; m_count = 0; m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check_val("init_count", {60'd0, count}, 64'd0);
    check_val("init_valid", {63'd0, out_valid}, 64'd0);
    check_val("init_ovf", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic snapshot and 1-cycle latency
    step(1'b1, CH_X, 8'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, CH_Y, 8'h34, 1'b0, 1'b0, 1'b0);
    step(1'b1, CH_Z, 8'h56, 1'b0, 1'b0, 1'b0);
    step(1'b1, CH_T, 8'h78, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("first_valid", {63'd0, out_valid}, 64'd1);
    check_val("first_frame", {32'd0, out_frame}, 64'h78563412);
    check_val("first_seq", {56'd0, out_seq}, 64'd0);
    step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Write-bypass into the committed frame
    step(1'b1, CH_T, 8'hAA, 1'b1, 1'b0, 1'b0);
    check_val("bypass_t", {56'd0, out_frame[31:24]}, 64'hAA);
    step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Simultaneous commit and pop mid-fill, then drain past empty
    step(1'b1, CH_X, 8'h01, 1'b1, 1'b0, 1'b0);
    step(1'b1, CH_Y, 8'h02, 1'b1, 1'b0, 1'b0);
    step(1'b1, CH_Z, 8'h03, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Overflow after 9 commits, seq 0..7 retained, next commit is seq 9
    reset_pulse();
    for (int i = 0; i < 9; i++) step(1'b1, i % C, 8'(i * 17), 1'b1, 1'b0, 1'b0);
    check_val("full_count", {60'd0, count}, 64'd8);
    check_val("ovf_set", {63'd0, overflow}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      check_val("pop_seq", {56'd0, out_seq}, 64'(i));
      step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("seq_after_drop", {56'd0, out_seq}, 64'd9);
    step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Full with commit and pop together, then set-over-clear precedence
    reset_pulse();
    for (int i = 0; i < 8; i++) step(1'b1, CH_Z, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b0);
    check_val("full_pop_count", {60'd0, count}, 64'd8);
    check_val("full_pop_ovf", {63'd0, overflow}, 64'd0);
    check_val("full_pop_head", {56'd0, out_seq}, 64'd1);
    step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_val("pre_rst_count", {60'd0, count}, 64'd3);
    check_val("pre_rst_ovf", {63'd0, overflow}, 64'd1);

    // Mid-stream async reset, then an all-zero frame with seq 0
    reset_pulse();
    step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("post_rst_frame", {32'd0, out_frame}, 64'd0);
    check_val("post_rst_seq", {56'd0, out_seq}, 64'd0);
    step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Out-of-range wr_sel on a 5-channel instance leaves all channels alone
    for (int k = 0; k < 5; k++) begin
      wr_en5 = 1'b1; wr_sel5 = 3'(k); wr_data5 = 8'(8'h11 * (k + 1));
      @(posedge clk); #1;
    end
    wr_en5 = 1'b1; wr_sel5 = 3'd5; wr_data5 = 8'hFF; commit5 = 1'b1;
    @(posedge clk); #1;
    wr_en5 = 1'b1; wr_sel5 = 3'd7; wr_data5 = 8'hEE; commit5 = 1'b0;
    @(posedge clk); #1;
    wr_en5 = 1'b0; commit5 = 1'b1;
    @(posedge clk); #1;
    commit5 = 1'b0;
    check_val("oor_count", {61'd0, count5}, 64'd2);
    check_val("oor_frame", {24'd0, out_frame5}, 64'h5544332211);
    check_val("oor_seq", {56'd0, out_seq5}, 64'd0);
    out_ready5 = 1'b1;
    @(posedge clk); #1;
    out_ready5 = 1'b0;
    check_val("oor_frame2", {24'd0, out_frame5}, 64'h5544332211);
    check_val("oor_seq2", {56'd0, out_seq5}, 64'd1);

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
